// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter (and the future receiver):
// FSM states, parity mode encodings and the minimum bit-period divisor.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int unsigned MIN_DIV = 2;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic par_bit(input logic [1:0] mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/serial_tx_cfg_if.sv
// Word handshake between a producer (master) and the serial transmitter (slave).
interface serial_tx_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/serial_baud_tick.sv
// Loadable bit-period down-counter: emits a one-cycle tick at the end of
// every period while enabled; the period is captured when loaded.
module serial_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_en,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_div <= '0;
    end else if (i_load) begin
      r_div <= i_div;
      r_cnt <= i_div - DIV_WIDTH'(1);
    end else if (i_en) begin
      if (r_cnt == '0) r_cnt <= r_div - DIV_WIDTH'(1);
      else             r_cnt <= r_cnt - DIV_WIDTH'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/serial_tx_cfg.sv
// Runtime-configurable serial transmitter with valid/ready word input.
// Parity support is compiled in only when SERIAL_TX_PARITY_EN is defined.
module serial_tx_cfg
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_tx_cfg_if.slave       s_in,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic                 busy,
  output logic                 done,
  output logic                 tx
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t             r_state, w_state_nxt;
  logic [BIT_W-1:0]      r_bit, w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                  r_stop2;
  logic                  r_tx, w_tx_nxt;
  logic                  w_accept, w_tick, w_tick_en, w_done;
  logic [DIV_WIDTH-1:0]  w_div;

`ifdef SERIAL_TX_PARITY_EN
  logic r_par_en, r_par_bit;
  logic w_par_en_in, w_par_bit_in;

  assign w_par_en_in  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
  assign w_par_bit_in = par_bit(cfg_parity, ^s_in.in_data);
`else
  logic w_unused_par;
  assign w_unused_par = ^cfg_parity;
`endif

  assign w_div = (cfg_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : cfg_div;

  // Done must not depend on in_valid, so it is decoded from registers only.
  assign w_done         = (r_state == ST_STOP) && w_tick && (r_bit == BIT_W'(r_stop2));
  assign s_in.in_ready  = (r_state == ST_IDLE) || w_done;
  assign w_accept       = s_in.in_valid && s_in.in_ready;
  assign w_data_nxt     = w_accept ? s_in.in_data : r_data;
  assign w_tick_en      = (r_state != ST_IDLE);

  serial_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (w_accept),
    .i_div  (w_div),
    .i_en   (w_tick_en),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_START;
          w_bit_nxt   = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
            w_bit_nxt   = '0;
`ifdef SERIAL_TX_PARITY_EN
            w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
`else
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt = ST_STOP;
          w_bit_nxt   = '0;
        end
      end
`endif
      ST_STOP: begin
        if (w_done) begin
          w_state_nxt = w_accept ? ST_START : ST_IDLE;
          w_bit_nxt   = '0;
        end else if (w_tick) begin
          w_bit_nxt = r_bit + BIT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Line level is decoded from the next state so tx leaves a flop.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_data_nxt[w_bit_nxt];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: w_tx_nxt = r_par_bit;
`endif
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_bit     <= '0;
      r_tx      <= 1'b1;
      r_data    <= '0;
      r_stop2   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      if (w_accept) begin
        r_data    <= s_in.in_data;
        r_stop2   <= cfg_stop2;
`ifdef SERIAL_TX_PARITY_EN
        r_par_en  <= w_par_en_in;
        r_par_bit <= w_par_bit_in;
`endif
      end
    end
  end

  assign tx   = r_tx;
  assign busy = (r_state != ST_IDLE);
  assign done = w_done;

endmodule

// File: tb/tb_serial_tx_cfg.sv
// Directed bench for serial_tx_cfg; parity checks follow SERIAL_TX_PARITY_EN.
module tb_serial_tx_cfg;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        busy, done, tx;
  logic        in_ready;

  int n_chk  = 0;
  int n_fail = 0;

  serial_tx_cfg_if #(.DATA_WIDTH(8)) u_if ();

  assign u_if.in_data  = in_data;
  assign u_if.in_valid = in_valid;
  assign in_ready      = u_if.in_ready;

  serial_tx_cfg #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_in       (u_if),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .busy       (busy),
    .done       (done),
    .tx         (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level in cycle c (1-based) after the accepting edge.
  function automatic logic exp_bit(input logic [7:0] d, input int div, input int pbits,
                                   input logic pbit, input int c);
    int b;
    b = (c - 1) / div;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pbits != 0 && b == 9) return pbit;
    return 1'b1;
  endfunction

  task automatic send_frame(input string tag, input logic [7:0] d, input logic [15:0] div_cfg,
                            input logic [1:0] par, input logic st2, input int div_eff,
                            input int pbits, input logic pbit, input logic [15:0] div_mid);
    int len, e_tx, e_busy, e_done;
    len = div_eff * (10 + pbits + int'(st2));
    e_tx = 0; e_busy = 0; e_done = 0;
    in_data = d; in_valid = 1'b1;
    cfg_div = div_cfg; cfg_parity = par; cfg_stop2 = st2;
    chk({tag, "_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~d;
    cfg_div = div_mid; cfg_parity = ~par; cfg_stop2 = ~st2;
    for (int c = 1; c <= len; c++) begin
      if (tx !== exp_bit(d, div_eff, pbits, pbit, c)) e_tx++;
      if (busy !== 1'b1) e_busy++;
      if (done !== (c == len)) e_done++;
      if (in_ready !== (c == len)) e_done++;
      @(posedge clk); #1;
    end
    chk({tag, "_tx_errs"}, e_tx, 0);
    chk({tag, "_busy_errs"}, e_busy, 0);
    chk({tag, "_done_errs"}, e_done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_tx"}, tx, 1);
  endtask

  initial begin
    int e_idle, e_tx, e_busy, e_done, e_rdy;
    logic [7:0] words [0:2];
    logic done_now;

    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0;
    cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    e_idle = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) e_idle++;
      @(posedge clk); #1;
    end
    chk("idle_errs", e_idle, 0);

    send_frame("A5", 8'hA5, 16'd4, 2'd0, 1'b0, 4, 0, 1'b0, 16'd4);

`ifdef SERIAL_TX_PARITY_EN
    send_frame("even07", 8'h07, 16'd4, 2'd1, 1'b0, 4, 1, 1'b1, 16'd4);
    send_frame("odd07", 8'h07, 16'd4, 2'd2, 1'b0, 4, 1, 1'b0, 16'd4);
    send_frame("st2even", 8'h07, 16'd4, 2'd1, 1'b1, 4, 1, 1'b1, 16'd4);
    send_frame("par3", 8'h07, 16'd4, 2'd3, 1'b0, 4, 0, 1'b0, 16'd4);
`else
    send_frame("par_ign", 8'h07, 16'd4, 2'd1, 1'b0, 4, 0, 1'b0, 16'd4);
    send_frame("st2", 8'h07, 16'd4, 2'd0, 1'b1, 4, 0, 1'b0, 16'd4);
    send_frame("par3", 8'h07, 16'd4, 2'd3, 1'b0, 4, 0, 1'b0, 16'd4);
`endif

    // Back-to-back: in_valid held, next word presented as soon as one is taken.
    words[0] = 8'h55; words[1] = 8'hAA; words[2] = 8'hFF;
    e_tx = 0; e_busy = 0; e_done = 0; e_rdy = 0;
    in_data = words[0]; in_valid = 1'b1;
    cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    @(posedge clk); #1;
    in_data = words[1];
    for (int c = 1; c <= 120; c++) begin
      if (tx !== exp_bit(words[(c-1)/40], 4, 0, 1'b0, ((c-1)%40)+1)) e_tx++;
      if (busy !== 1'b1) e_busy++;
      if (done !== (((c-1)%40) == 39)) e_done++;
      if (in_ready !== (((c-1)%40) == 39)) e_rdy++;
      done_now = done;
      @(posedge clk); #1;
      if (done_now && c == 40) in_data = words[2];
      if (done_now && c == 80) in_valid = 1'b0;
    end
    chk("b2b_tx_errs", e_tx, 0);
    chk("b2b_busy_errs", e_busy, 0);
    chk("b2b_done_errs", e_done, 0);
    chk("b2b_ready_errs", e_rdy, 0);
    chk("b2b_idle_busy", busy, 0);

    send_frame("div0", 8'h3C, 16'd0, 2'd0, 1'b0, 2, 0, 1'b0, 16'd0);
    send_frame("div1", 8'hC3, 16'd1, 2'd0, 1'b0, 2, 0, 1'b0, 16'd1);
    send_frame("mid_chg", 8'h96, 16'd4, 2'd0, 1'b0, 4, 0, 1'b0, 16'd10);
    send_frame("div10", 8'h5A, 16'd10, 2'd0, 1'b0, 10, 0, 1'b0, 16'd10);

    // Reset in the middle of data bit 3 (a zero bit of 0xA5).
    in_data = 8'hA5; in_valid = 1'b1;
    cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (17) begin
      @(posedge clk); #1;
    end
    chk("mid_bit3_tx", tx, 0);
    chk("mid_bit3_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ready", in_ready, 1);
    e_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || tx !== 1'b1) e_done++;
    end
    chk("arst_hold_errs", e_done, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    send_frame("post_rst", 8'h81, 16'd4, 2'd0, 1'b0, 4, 0, 1'b0, 16'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
